// File: rtl/graphic_box_unit.sv
// Scanline box renderer: draws one line (dy) of a rectangle into the line
// buffer through the shared dx/wr/data write port, with fill, outline,
// transparent-outline and dashed modes, border thickness and ready stalls.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; inputs latched when start is seen
// SETUP  | compute edge extents, clip to screen, decide draw or skip
// DRAW   | one pixel column per accepted cycle, px from x0 to clipped x_end
// DONE   | one-cycle done pulse, start ignored
module graphic_box_unit #(
    parameter int XW         = 12,
    parameter int CW         = 16,
    parameter int H_RES      = 320,
    parameter int DASH_SHIFT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [XW-1:0] dy,
    input  logic [XW-1:0] x0,
    input  logic [XW-1:0] y0,
    input  logic [XW-1:0] width,
    input  logic [XW-1:0] height,
    input  logic [1:0]    mode,
    input  logic [3:0]    border,
    input  logic [CW-1:0] fg_color,
    input  logic [CW-1:0] bg_color,
    input  logic          ready,
    output logic [XW-1:0] dx,
    output logic          wr,
    output logic [CW-1:0] data,
    output logic          busy,
    output logic          done,
    output logic [31:0]   cycles
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_DRAW  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [XW:0] H_RES_V  = (XW+1)'(H_RES);
    localparam logic [XW:0] H_LAST_V = (XW+1)'(H_RES - 1);

    state_t        state_q, state_d;
    logic [XW-1:0] px_q, px_d;
    logic [XW-1:0] x0_q, x0_d;
    logic [XW-1:0] y0_q, y0_d;
    logic [XW-1:0] dy_q, dy_d;
    logic [XW-1:0] w_q, w_d;
    logic [XW-1:0] h_q, h_d;
    logic [1:0]    mode_q, mode_d;
    logic [3:0]    border_q, border_d;
    logic [CW-1:0] fg_q, fg_d;
    logic [CW-1:0] bg_q, bg_d;
    logic [XW:0]   xe_q, xe_d;     // unclipped right edge, used for edge test
    logic [XW-1:0] xc_q, xc_d;     // right edge clipped to the screen
    logic [XW:0]   ye_q, ye_d;
    logic [31:0]   cyc_q, cyc_d;

    logic [XW:0]   xe_calc, ye_calc;
    logic [XW-1:0] xc_calc;
    logic          skip;
    logic [XW:0]   b_ext, off_l, off_r, off_t, off_b;
    logic [3:0]    b_eff;
    logic          is_edge;
    logic          wr_o;
    logic [CW-1:0] data_o;

    // Geometry for SETUP: extents in XW+1 bits so x0+width cannot wrap.
    always_comb begin
        xe_calc = {1'b0, x0_q} + {1'b0, w_q} - 1'b1;
        ye_calc = {1'b0, y0_q} + {1'b0, h_q} - 1'b1;
        xc_calc = (xe_calc > H_LAST_V) ? H_LAST_V[XW-1:0] : xe_calc[XW-1:0];
        skip    = (w_q == '0) || (h_q == '0) || (dy_q < y0_q) ||
                  ({1'b0, dy_q} > ye_calc) || ({1'b0, x0_q} >= H_RES_V);
    end

    // Pixel decode from registered state; only drives the port in DRAW.
    always_comb begin
        b_eff   = (border_q == 4'd0) ? 4'd1 : border_q;
        b_ext   = {{(XW-3){1'b0}}, b_eff};
        off_l   = {1'b0, px_q} - {1'b0, x0_q};
        off_r   = xe_q - {1'b0, px_q};
        off_t   = {1'b0, dy_q} - {1'b0, y0_q};
        off_b   = ye_q - {1'b0, dy_q};
        is_edge = (off_l < b_ext) || (off_r < b_ext) ||
                  (off_t < b_ext) || (off_b < b_ext);
        wr_o    = 1'b0;
        data_o  = '0;
        if (state_q == S_DRAW) begin
            case (mode_q)
                2'd0: begin wr_o = 1'b1;    data_o = fg_q; end
                2'd1: begin wr_o = 1'b1;    data_o = is_edge ? fg_q : bg_q; end
                2'd2: begin wr_o = is_edge; data_o = fg_q; end
                default: begin
                    wr_o   = 1'b1;
                    data_o = off_l[DASH_SHIFT] ? bg_q : fg_q;
                end
            endcase
        end
    end

    // Next-state, input latch and column stepping.
    always_comb begin
        state_d  = state_q;
        px_d     = px_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        dy_d     = dy_q;
        w_d      = w_q;
        h_d      = h_q;
        mode_d   = mode_q;
        border_d = border_q;
        fg_d     = fg_q;
        bg_d     = bg_q;
        xe_d     = xe_q;
        xc_d     = xc_q;
        ye_d     = ye_q;
        cyc_d    = cyc_q + 32'd1;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x0_d     = x0;
                    y0_d     = y0;
                    dy_d     = dy;
                    w_d      = width;
                    h_d      = height;
                    mode_d   = mode;
                    border_d = border;
                    fg_d     = fg_color;
                    bg_d     = bg_color;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                xe_d    = xe_calc;
                xc_d    = xc_calc;
                ye_d    = ye_calc;
                px_d    = x0_q;
                state_d = skip ? S_DONE : S_DRAW;
            end
            S_DRAW: begin
                if (!wr_o || ready) begin
                    if (px_q == xc_q) begin
                        state_d = S_DONE;
                    end else begin
                        px_d = px_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous reset; reset aborts a scanline outright.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            px_q     <= '0;
            x0_q     <= '0;
            y0_q     <= '0;
            dy_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            mode_q   <= '0;
            border_q <= '0;
            fg_q     <= '0;
            bg_q     <= '0;
            xe_q     <= '0;
            xc_q     <= '0;
            ye_q     <= '0;
            cyc_q    <= '0;
        end else begin
            state_q  <= state_d;
            px_q     <= px_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            dy_q     <= dy_d;
            w_q      <= w_d;
            h_q      <= h_d;
            mode_q   <= mode_d;
            border_q <= border_d;
            fg_q     <= fg_d;
            bg_q     <= bg_d;
            xe_q     <= xe_d;
            xc_q     <= xc_d;
            ye_q     <= ye_d;
            cyc_q    <= cyc_d;
        end
    end

    assign dx     = px_q;
    assign wr     = wr_o;
    assign data   = data_o;
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign cycles = cyc_q;

endmodule
